// File: rtl/btn_cmd_ctrl_pkg.sv
// Shared definitions for the push-button command controller.
//   run_state_t     : run/stop FSM encoding used by btn_cmd_ctrl
//   DB_SAMPLES_MIN/MAX : legal range for the debounce history depth
//   CH_*            : channel index of each button in the debouncer bank
//   clamp_db()      : folds a requested debounce depth into the legal range
package btn_cmd_ctrl_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  localparam int DB_SAMPLES_MIN = 2;
  localparam int DB_SAMPLES_MAX = 16;

  localparam int CH_RUN  = 0;
  localparam int CH_CLR  = 1;
  localparam int CH_DIR  = 2;
  localparam int NUM_BTN = 3;

  function automatic int clamp_db(input int n);
    if (n < DB_SAMPLES_MIN) return DB_SAMPLES_MIN;
    if (n > DB_SAMPLES_MAX) return DB_SAMPLES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-FF synchronizer, tick-sampled history,
// debounced level and a one-clk press pulse on the rising debounced level.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   tick  : shared one-clk sample strobe
//   btn   : raw asynchronous button (active-high)
//   press : one-clk pulse, the cycle after the debounced level rises
module btn_debounce
  import btn_cmd_ctrl_pkg::*;
#(
  parameter int DB_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic press
);

  logic [1:0]            sync_reg;
  logic [DB_SAMPLES-1:0] hist_reg;
  logic [DB_SAMPLES-1:0] hist_shift;
  logic                  level_reg;
  logic                  level_d_reg;

  // Level decision uses the history including the sample taken this tick,
  // so the level moves on the same edge as the deciding sample.
  assign hist_shift = {hist_reg[DB_SAMPLES-2:0], sync_reg[1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg    <= '0;
      hist_reg    <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      press       <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      if (tick) begin
        hist_reg <= hist_shift;
        if (&hist_shift) begin
          level_reg <= 1'b1;
        end else if (~|hist_shift) begin
          level_reg <= 1'b0;
        end
      end
      level_d_reg <= level_reg;
      // Rising edge of the debounced level only; releases are silent.
      press       <= level_reg & ~level_d_reg;
    end
  end

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Three-button command controller: run/stop toggle, counter clear and
// count-direction toggle, with debounced inputs and flop-driven outputs.
//   clk     : system clock, all state on rising edge
//   rst     : asynchronous active-low reset
//   btn_run : raw button, press toggles run/stop
//   btn_clr : raw button, press forces STOP and pulses sw1_clr
//   btn_dir : raw button, press toggles sw2_inc
//   sw0_stp : 1 = counter stopped
//   sw1_clr : one-clk clear pulse
//   sw2_inc : 0 = count up, 1 = count down
module btn_cmd_ctrl
  import btn_cmd_ctrl_pkg::*;
#(
  parameter int DIV_DEBOUNCE = 100_000,
  parameter int DB_SAMPLES   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_clr,
  input  logic btn_dir,
  output logic sw0_stp,
  output logic sw1_clr,
  output logic sw2_inc
);

  localparam int            CW        = (DIV_DEBOUNCE > 1) ? $clog2(DIV_DEBOUNCE) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV_DEBOUNCE - 1);
  // Out-of-range depths are folded into the supported range.
  localparam int            DB_EFF    = clamp_db(DB_SAMPLES);

  logic [CW-1:0]      tick_cnt_reg;
  logic               tick;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  run_state_t         state_reg;
  run_state_t         state_next;

  // Free-running sample divider; the first tick lands DIV_DEBOUNCE clk
  // after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CW'(1);
    end
  end

  assign tick = (tick_cnt_reg == TICK_LAST);

  assign btn_raw[CH_RUN] = btn_run;
  assign btn_raw[CH_CLR] = btn_clr;
  assign btn_raw[CH_DIR] = btn_dir;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DB_SAMPLES(DB_EFF)
      ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .btn  (btn_raw[gi]),
        .press(press[gi])
      );
    end
  endgenerate

  // Clear has priority: a run press in the same cycle is dropped.
  always_comb begin
    state_next = state_reg;
    if (press[CH_CLR]) begin
      state_next = STOP;
    end else if (press[CH_RUN]) begin
      state_next = (state_reg == STOP) ? RUN : STOP;
    end
  end

  // Outputs are registered from the next-state decode so sw1_clr and the
  // STOP indication appear on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= STOP;
      sw0_stp   <= 1'b1;
      sw1_clr   <= 1'b0;
      sw2_inc   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sw0_stp   <= (state_next == STOP);
      sw1_clr   <= press[CH_CLR];
      sw2_inc   <= sw2_inc ^ press[CH_DIR];
    end
  end

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Testbench for btn_cmd_ctrl: table-driven phases, hand-written reset
// corner case and randomized button activity against a reference model
// built from run-length counting and edge-number event scheduling.
module tb_btn_cmd_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_run = 1'b0;
  logic btn_clr = 1'b0;
  logic btn_dir = 1'b0;
  logic sw0_stp;
  logic sw1_clr;
  logic sw2_inc;

  always #5 clk = ~clk;

  btn_cmd_ctrl #(
    .DIV_DEBOUNCE(DIV),
    .DB_SAMPLES  (DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_run(btn_run),
    .btn_clr(btn_clr),
    .btn_dir(btn_dir),
    .sw0_stp(sw0_stp),
    .sw1_clr(sw1_clr),
    .sw2_inc(sw2_inc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // n        : active edges since reset release
  // rq       : last raw samples per button (synchronized view = 2 edges old)
  // ones/zeros_run : consecutive equal tick samples per button
  // eff      : edge number at which a press takes effect on the outputs
  int  n;
  bit  rq [3][$];
  int  ones_run [3];
  int  zeros_run [3];
  int  eff [3];
  bit  lvl [3];
  bit  m_stp, m_clr, m_inc;

  task automatic model_reset();
    n = 0;
    for (int ch = 0; ch < 3; ch++) begin
      rq[ch].delete();
      ones_run[ch]  = 0;
      zeros_run[ch] = DB;
      eff[ch]       = -1;
      lvl[ch]       = 1'b0;
    end
    m_stp = 1'b1;
    m_clr = 1'b0;
    m_inc = 1'b0;
  endtask

  task automatic model_edge();
    bit raw [3];
    bit s;
    raw[0] = btn_run;
    raw[1] = btn_clr;
    raw[2] = btn_dir;
    if (rst !== 1'b1) begin
      model_reset();
      return;
    end
    n++;
    m_clr = 1'b0;
    if (eff[1] == n) begin
      m_stp = 1'b1;
      m_clr = 1'b1;
    end else if (eff[0] == n) begin
      m_stp = ~m_stp;
    end
    if (eff[2] == n) m_inc = ~m_inc;
    for (int ch = 0; ch < 3; ch++) begin
      rq[ch].push_back(raw[ch]);
      if (rq[ch].size() > 3) void'(rq[ch].pop_front());
      if (n % DIV == 0) begin
        s = (rq[ch].size() == 3) ? rq[ch][0] : 1'b0;
        if (s) begin
          ones_run[ch]  = (ones_run[ch] < DB) ? ones_run[ch] + 1 : DB;
          zeros_run[ch] = 0;
        end else begin
          zeros_run[ch] = (zeros_run[ch] < DB) ? zeros_run[ch] + 1 : DB;
          ones_run[ch]  = 0;
        end
        if (!lvl[ch] && ones_run[ch] >= DB) begin
          lvl[ch] = 1'b1;
          eff[ch] = n + 2;
        end else if (lvl[ch] && zeros_run[ch] >= DB) begin
          lvl[ch] = 1'b0;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  int   ph_pulses, ph_falls, ph_first_fall, ph_cyc;
  logic prev_stp = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic phase_start();
    ph_pulses     = 0;
    ph_falls      = 0;
    ph_first_fall = -1;
    ph_cyc        = 0;
  endtask

  // One clock: sample #1 after the edge, advance the model, compare.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ph_cyc++;
    model_edge();
    check("outputs{stp,clr,inc}", {29'd0, sw0_stp, sw1_clr, sw2_inc},
          {29'd0, m_stp, m_clr, m_inc});
    if (sw1_clr === 1'b1) begin
      ph_pulses++;
      check("stp_with_clr", {31'd0, sw0_stp}, 32'd1);
    end
    if (prev_stp === 1'b1 && sw0_stp === 1'b0) begin
      ph_falls++;
      if (ph_first_fall < 0) ph_first_fall = ph_cyc;
    end
    prev_stp = sw0_stp;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst_v;
    logic run;
    logic run_tog;
    logic clr;
    logic dir;
    int   cycles;
    logic exp_stp;
    logic exp_inc;
    int   exp_pulses;
    int   exp_falls;
    int   fall_max;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic ru, input logic tg, input logic c,
                              input logic d, input int cy, input logic es, input logic ei,
                              input int ep, input int ef, input int fm);
    vec_t v;
    v.rst_v = r; v.run = ru; v.run_tog = tg; v.clr = c; v.dir = d; v.cycles = cy;
    v.exp_stp = es; v.exp_inc = ei; v.exp_pulses = ep; v.exp_falls = ef; v.fall_max = fm;
    return v;
  endfunction

  int seg_dur;

  initial begin
    //               rst run tog clr dir cyc  stp inc pul fal fmax
    tbl[0]  = mk(1'b0, 0, 0, 0, 0,   5, 1'b1, 1'b0, 0, 0,  0); // held in reset
    tbl[1]  = mk(1'b1, 0, 0, 0, 0, 200, 1'b1, 1'b0, 0, 0,  0); // idle after reset
    tbl[2]  = mk(1'b1, 1, 0, 0, 0,  40, 1'b0, 1'b0, 0, 1, 22); // run press -> RUN
    tbl[3]  = mk(1'b1, 1, 1, 0, 0,  30, 1'b0, 1'b0, 0, 0,  0); // bouncing run
    tbl[4]  = mk(1'b1, 0, 0, 0, 0,  40, 1'b0, 1'b0, 0, 0,  0); // release
    tbl[5]  = mk(1'b1, 0, 0, 1, 0,  40, 1'b1, 1'b0, 1, 0,  0); // clr in RUN
    tbl[6]  = mk(1'b1, 0, 0, 0, 0,  40, 1'b1, 1'b0, 0, 0,  0);
    tbl[7]  = mk(1'b1, 1, 0, 1, 0,  40, 1'b1, 1'b0, 1, 0,  0); // clr + run together
    tbl[8]  = mk(1'b1, 0, 0, 0, 0,  40, 1'b1, 1'b0, 0, 0,  0);
    tbl[9]  = mk(1'b1, 0, 0, 0, 1,  40, 1'b1, 1'b1, 0, 0,  0); // dir #1
    tbl[10] = mk(1'b1, 0, 0, 0, 0,  40, 1'b1, 1'b1, 0, 0,  0);
    tbl[11] = mk(1'b1, 0, 0, 0, 1,  40, 1'b1, 1'b0, 0, 0,  0); // dir #2
    tbl[12] = mk(1'b1, 0, 0, 0, 0,  40, 1'b1, 1'b0, 0, 0,  0);
    tbl[13] = mk(1'b1, 0, 0, 0, 1,  40, 1'b1, 1'b1, 0, 0,  0); // dir #3
    tbl[14] = mk(1'b1, 0, 0, 0, 0,  40, 1'b1, 1'b1, 0, 0,  0);

    model_reset();

    for (int i = 0; i < NV; i++) begin
      rst     = tbl[i].rst_v;
      btn_run = tbl[i].run;
      btn_clr = tbl[i].clr;
      btn_dir = tbl[i].dir;
      phase_start();
      for (int c = 0; c < tbl[i].cycles; c++) begin
        if (tbl[i].run_tog) btn_run = ((c / 3) % 2 == 1);
        step();
      end
      check("vec_stp",    {31'd0, sw0_stp}, {31'd0, tbl[i].exp_stp});
      check("vec_inc",    {31'd0, sw2_inc}, {31'd0, tbl[i].exp_inc});
      check("vec_pulses", ph_pulses, tbl[i].exp_pulses);
      check("vec_falls",  ph_falls,  tbl[i].exp_falls);
      if (tbl[i].fall_max > 0) begin
        total++;
        if (ph_first_fall < 1 || ph_first_fall > tbl[i].fall_max) begin
          bad++;
          $display("FAIL fall_latency: got %0d clk, required 1..%0d (vec %0d)",
                   ph_first_fall, tbl[i].fall_max, i);
        end
      end
      $display("vec %0d: stp=%0b clr_pulses=%0d inc=%0b stp_falls=%0d first_fall=%0d",
               i, sw0_stp, ph_pulses, sw2_inc, ph_falls, ph_first_fall);
    end

    // Reset 10 clk into a run press, button still held at release.
    btn_run = 1'b1;
    btn_clr = 1'b0;
    btn_dir = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    repeat (5) step();
    check("rst_hold_stp", {31'd0, sw0_stp}, 32'd1);
    check("rst_hold_inc", {31'd0, sw2_inc}, 32'd0);
    rst = 1'b1;
    phase_start();
    repeat (40) step();
    check("rst_press_falls", ph_falls, 1);
    check("rst_press_latency", ph_first_fall, DB * DIV + 2);
    check("rst_press_pulses", ph_pulses, 0);
    $display("reset-mid-press: stp_falls=%0d first_fall=%0d stp=%0b",
             ph_falls, ph_first_fall, sw0_stp);
    btn_run = 1'b0;
    phase_start();
    repeat (40) step();
    check("rst_release_stp", {31'd0, sw0_stp}, 32'd0);
    check("rst_release_falls", ph_falls, 0);
    $display("release after reset press: stp=%0b", sw0_stp);

    // Randomized segments: short bounces and long holds, rare resets.
    for (int k = 0; k < 150; k++) begin
      seg_dur = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(7, 30);
      btn_run = 1'($urandom_range(0, 1));
      btn_clr = ($urandom_range(0, 3) == 0);
      btn_dir = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 29) != 0);
      repeat (seg_dur) step();
      $display("rand %0d: run=%0b clr=%0b dir=%0b rst=%0b dur=%0d -> stp=%0b inc=%0b",
               k, btn_run, btn_clr, btn_dir, rst, seg_dur, sw0_stp, sw2_inc);
    end
    rst = 1'b1;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    btn_dir = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_cmd_ctrl.md
BTN_CMD_CTRL -- requirements
Module: btn_cmd_ctrl

Interface
REQ-001 Parameter DIV_DEBOUNCE, default 100_000, clk cycles per debounce sample tick (1 kHz at 100 MHz).
REQ-002 Parameter DB_SAMPLES, default 8, consecutive equal samples needed to change a debounced level; legal range 2..16.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn_run  input  1  raw push button, asynchronous, active-high; a press toggles run/stop.
REQ-006 btn_clr  input  1  raw push button, asynchronous, active-high; a press requests a counter clear.
REQ-007 btn_dir  input  1  raw push button, asynchronous, active-high; a press toggles count direction.
REQ-008 sw0_stp  output  1  level; 1 = counter stopped.
REQ-009 sw1_clr  output  1  one-clk pulse; 1 = clear counter.
REQ-010 sw2_inc  output  1  level; 0 = count up, 1 = count down.

Function
REQ-011 Each raw button SHALL pass a 2-FF synchronizer before any other logic.
REQ-012 A shared sample tick SHALL assert for one clk every DIV_DEBOUNCE cycles, using a free-running counter of width $clog2(DIV_DEBOUNCE) that wraps at DIV_DEBOUNCE-1.
REQ-013 On each tick, each channel SHALL shift its synchronized input into a DB_SAMPLES-bit history register.
REQ-014 Debounced level SHALL go to 1 only when all DB_SAMPLES bits are 1, and to 0 only when all are 0; otherwise it holds.
REQ-015 A press event SHALL be a one-clk pulse in the cycle after the debounced level rises; releases produce no event.
REQ-016 Run FSM states SHALL be STOP (sw0_stp=1) and RUN (sw0_stp=0).
REQ-017 In STOP, run press -> RUN; in RUN, run press -> STOP.
REQ-018 In either state, clr press SHALL force STOP and pulse sw1_clr for exactly one clk, registered, with sw1_clr and the STOP transition in the same cycle.
REQ-019 Simultaneous clr and run press events SHALL resolve as clr only; the run press is discarded.
REQ-020 Dir press SHALL toggle sw2_inc in the following cycle, independent of FSM state, including during a clr pulse.
REQ-021 A button held indefinitely SHALL produce exactly one press event; a bounce shorter than DB_SAMPLES ticks SHALL produce none.
REQ-022 Worst-case press-to-output latency SHALL be 2 + DB_SAMPLES*DIV_DEBOUNCE + 2 clk.
REQ-023 All outputs SHALL be driven directly from flops.

Reset
REQ-024 While rst=0, the block SHALL hold sw0_stp=1, sw1_clr=0, sw2_inc=0, FSM=STOP, tick counter=0, synchronizers=0, histories=0 and debounced levels=0.
REQ-025 Reset mid-press SHALL discard the press; a button still held at release SHALL generate a new event after full debounce.
REQ-026 After rst rises, the first tick SHALL occur DIV_DEBOUNCE clk later.

Structure
REQ-027 The FSM state encoding (STOP, RUN) and the DB_SAMPLES range limits SHALL live in the shared project package.
REQ-028 One sub-module, btn_debounce (synchronizer, history, level, press pulse, tick input), SHALL be instantiated three times; the tick counter and FSM SHALL stay in btn_cmd_ctrl.

Verification (bench uses DIV_DEBOUNCE=4, DB_SAMPLES=4)
REQ-029 Release reset, no buttons -> sw0_stp=1, sw1_clr=0, sw2_inc=0 for 200 clk.
REQ-030 Hold btn_run 40 clk, then toggle it 0/1 every 3 clk for 30 clk -> exactly one STOP->RUN transition, sw0_stp falling within 22 clk of the first assertion.
REQ-031 In RUN, press btn_clr 40 clk -> one sw1_clr pulse exactly 1 clk wide, sw0_stp=1 in the same cycle.
REQ-032 Assert btn_clr and btn_run on the same edge for 40 clk -> one sw1_clr pulse, sw0_stp stays 1, no RUN entry.
REQ-033 Press btn_dir 3 times (40 clk on, 40 off) -> sw2_inc sequence 1,0,1.
REQ-034 Assert rst=0 10 clk into a btn_run press, release with button held -> RUN reached once, a full debounce after reset release.
